// File: rtl/dmawr_timer_bank.sv
// Bank of independent trigger-to-pulse timers with per-channel trigger source/edge,
// output polarity and one-shot / retriggerable / free-running modes.
module dmawr_timer_bank #(
    parameter int  NUM_TIMERS = 4,
    parameter int  NUM_TRIG   = 8,
    parameter int  CNT_WIDTH  = 24,
    localparam int ADDR_W     = $clog2(NUM_TIMERS) + 2
) (
    input  logic                  sysclk,
    input  logic                  sysrst_n,
    input  logic                  reg_write,
    input  logic                  reg_read,
    input  logic [ADDR_W-1:0]     reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  reg_rdata_valid,
    input  logic [NUM_TRIG-1:0]   trig_in,
    output logic [NUM_TIMERS-1:0] timer_out,
    output logic [NUM_TIMERS-1:0] irq_end
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    logic [NUM_TRIG-1:0]              r_trig_d;
    logic [255:0]                     w_trig_cur;
    logic [255:0]                     w_trig_prev;
    logic [255:0]                     w_rise;
    logic [255:0]                     w_fall;
    logic [31:0]                      w_chan;
    logic [NUM_TIMERS-1:0][31:0]      w_ch_rdata;
    logic [31:0]                      w_rd_mux;
    logic [31:0]                      r_rdata;
    logic                             r_rdata_valid;
    logic                             w_unused;

    // Zero padding to 256 lanes means a select beyond NUM_TRIG never sees an edge.
    assign w_trig_cur  = 256'(trig_in);
    assign w_trig_prev = 256'(r_trig_d);
    assign w_rise      = w_trig_cur & ~w_trig_prev;
    assign w_fall      = ~w_trig_cur & w_trig_prev;
    assign w_chan      = 32'(reg_addr >> 2);
    assign w_unused    = ^reg_wdata;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_trig_d <= '0;
        end else begin
            r_trig_d <= trig_in;
        end
    end

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
        state_t               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] r_delay;
        logic [CNT_WIDTH-1:0] r_width;
        logic                 r_en;
        logic                 r_soft;
        logic                 r_pol;
        logic                 r_edge;
        logic                 r_missed;
        logic                 r_out;
        logic                 r_irq;
        logic [1:0]           r_mode;
        logic [7:0]           r_sel;
        logic                 w_sel_ch;
        logic                 w_wr;
        logic                 w_ctrl_wr;
        logic                 w_trig;
        logic                 w_retrig;
        logic                 w_freerun;
        logic [CNT_WIDTH-1:0] w_width_m1;

        assign w_sel_ch   = (w_chan == 32'(gi));
        assign w_wr       = reg_write & w_sel_ch;
        assign w_ctrl_wr  = w_wr & (reg_addr[1:0] == 2'd0);
        assign w_trig     = (r_edge ? w_fall[r_sel] : w_rise[r_sel]) | r_soft;
        assign w_retrig   = (r_mode == 2'b01);
        assign w_freerun  = (r_mode == 2'b10);
        // The ACTIVE counter runs down to zero, so it is loaded with WIDTH-1 (WIDTH 0 acts as 1).
        assign w_width_m1 = (r_width == '0) ? '0 : r_width - CNT_WIDTH'(1);

        always_ff @(posedge sysclk or negedge sysrst_n) begin
            if (!sysrst_n) begin
                r_en    <= 1'b0;
                r_mode  <= 2'b00;
                r_soft  <= 1'b0;
                r_pol   <= 1'b0;
                r_edge  <= 1'b0;
                r_sel   <= 8'd0;
                r_delay <= '0;
                r_width <= '0;
            end else begin
                r_soft <= 1'b0;
                if (w_wr) begin
                    case (reg_addr[1:0])
                        2'd0: begin
                            r_en   <= reg_wdata[0];
                            r_mode <= reg_wdata[2:1];
                            r_soft <= reg_wdata[3];
                            r_pol  <= reg_wdata[4];
                            r_edge <= reg_wdata[5];
                            r_sel  <= reg_wdata[15:8];
                        end
                        2'd1:    r_delay <= reg_wdata[CNT_WIDTH-1:0];
                        2'd2:    r_width <= reg_wdata[CNT_WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end

        always_ff @(posedge sysclk or negedge sysrst_n) begin
            if (!sysrst_n) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_out    <= 1'b0;
                r_irq    <= 1'b0;
                r_missed <= 1'b0;
            end else begin
                r_irq <= 1'b0;
                r_out <= r_pol;
                if (w_ctrl_wr) begin
                    r_missed <= 1'b0;
                end else if (r_en && w_trig && (r_state != S_IDLE) && !w_retrig) begin
                    r_missed <= 1'b1;
                end
                if (!r_en) begin
                    r_state <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_trig) begin
                                r_state <= S_DELAY;
                                r_cnt   <= r_delay;
                            end
                        end
                        S_DELAY: begin
                            if (w_trig && w_retrig) begin
                                r_cnt <= r_delay;
                            end else if (r_cnt == '0) begin
                                r_state <= S_ACTIVE;
                                r_cnt   <= w_width_m1;
                                r_out   <= ~r_pol;
                            end else begin
                                r_cnt <= r_cnt - CNT_WIDTH'(1);
                            end
                        end
                        S_ACTIVE: begin
                            if (w_trig && w_retrig) begin
                                r_state <= S_DELAY;
                                r_cnt   <= r_delay;
                            end else if (r_cnt == '0) begin
                                r_irq <= 1'b1;
                                if (w_freerun) begin
                                    r_state <= S_DELAY;
                                    r_cnt   <= r_delay;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_cnt <= r_cnt - CNT_WIDTH'(1);
                                r_out <= ~r_pol;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end

        assign w_ch_rdata[gi] = !w_sel_ch ? 32'd0 :
            (reg_addr[1:0] == 2'd0) ? {16'd0, r_sel, 2'b00, r_edge, r_pol, 1'b0, r_mode, r_en} :
            (reg_addr[1:0] == 2'd1) ? 32'(r_delay) :
            (reg_addr[1:0] == 2'd2) ? 32'(r_width) :
                                      {23'd0, r_missed, 6'd0, r_state};
        assign timer_out[gi] = r_out;
        assign irq_end[gi]   = r_irq;
    end

    // At most one channel decodes the address, so an OR acts as the read mux.
    always_comb begin
        w_rd_mux = 32'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_rd_mux = w_rd_mux | w_ch_rdata[i];
        end
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= reg_read;
            if (reg_read) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign reg_rdata       = r_rdata;
    assign reg_rdata_valid = r_rdata_valid;

endmodule
